// File: rtl/periph_bus_bridge.sv
// Byte-stream command bridge: decodes W/R commands from an RX byte stream, masters one
// peripheral-bus access via the arbiter and streams the reply. Optional macro: CHECKSUM_EN.
module periph_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter logic [7:0]  OP_READ        = 8'h52
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [4:0]  A,
  output logic [31:0] WD,
  output logic        WE,
  input  logic [31:0] RD
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_DATA, ST_CHK, ST_REQ, ST_ACCESS, ST_RESP
  } state_t;
  localparam state_t ST_CMD_DONE = ST_CHK;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_DATA, ST_REQ, ST_ACCESS, ST_RESP
  } state_t;
  localparam state_t ST_CMD_DONE = ST_REQ;
`endif

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (i)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

`ifdef CHECKSUM_EN
  function automatic logic [7:0] fold_chk(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  state_t        state_r, state_s;
  logic          is_wr_r, is_wr_s;
  logic [4:0]    a_r, a_s;
  logic [31:0]   wd_r, wd_s;
  logic          we_r, we_s;
  logic          req_r, req_s;
  logic          txv_r, txv_s;
  logic [7:0]    txd_r, txd_s;
  logic          rxr_r, rxr_s;
  logic [1:0]    cnt_r, cnt_s;
  logic [1:0]    idx_r, idx_s;
  logic [1:0]    last_r, last_s;
  logic [31:0]   resp_r, resp_s;
  logic [CW-1:0] tmo_r, tmo_s;
  logic          rx_acc_s;
  logic          tmo_hit_s;
`ifdef CHECKSUM_EN
  logic [7:0]    chk_r, chk_s;
`endif

  assign rx_acc_s  = rx_valid & rxr_r;
  assign tmo_hit_s = (tmo_r == TMAX);

  // Next-state and next-output computation; every output is registered from these.
  always_comb begin
    state_s = state_r;
    is_wr_s = is_wr_r;
    a_s     = a_r;
    wd_s    = wd_r;
    txv_s   = txv_r;
    txd_s   = txd_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    last_s  = last_r;
    resp_s  = resp_r;
    tmo_s   = {CW{1'b0}};
`ifdef CHECKSUM_EN
    chk_s   = chk_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (rx_acc_s) begin
          if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
            is_wr_s = (rx_data == OP_WRITE);
            state_s = ST_ADDR;
`ifdef CHECKSUM_EN
            chk_s   = rx_data;
`endif
          end else begin
            state_s = ST_RESP;
            txv_s   = 1'b1;
            txd_s   = 8'h3F;
            idx_s   = 2'd0;
            last_s  = 2'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_acc_s) begin
          if (rx_data[7:5] != 3'b000) begin
            state_s = ST_RESP;
            txv_s   = 1'b1;
            txd_s   = 8'h45;
            idx_s   = 2'd0;
            last_s  = 2'd0;
          end else begin
            a_s     = rx_data[4:0];
            cnt_s   = 2'd0;
            state_s = is_wr_r ? ST_DATA : ST_CMD_DONE;
`ifdef CHECKSUM_EN
            chk_s   = fold_chk(chk_r, rx_data);
`endif
          end
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
        end else begin
          tmo_s = tmo_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (rx_acc_s) begin
          wd_s    = put_byte(wd_r, cnt_r, rx_data);
          cnt_s   = cnt_r + 2'd1;
          state_s = (cnt_r == 2'd3) ? ST_CMD_DONE : ST_DATA;
`ifdef CHECKSUM_EN
          chk_s   = fold_chk(chk_r, rx_data);
`endif
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
        end else begin
          tmo_s = tmo_r + CW'(1);
        end
      end
`ifdef CHECKSUM_EN
      ST_CHK: begin
        if (rx_acc_s) begin
          if (rx_data == chk_r) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_RESP;
            txv_s   = 1'b1;
            txd_s   = 8'h45;
            idx_s   = 2'd0;
            last_s  = 2'd0;
          end
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
        end else begin
          tmo_s = tmo_r + CW'(1);
        end
      end
`endif
      ST_REQ: begin
        state_s = bus_gnt ? ST_ACCESS : ST_REQ;
      end
      ST_ACCESS: begin
        state_s = ST_RESP;
        txv_s   = 1'b1;
        idx_s   = 2'd0;
        if (is_wr_r) begin
          txd_s  = 8'h4B;
          last_s = 2'd0;
        end else begin
          resp_s = RD;
          txd_s  = RD[7:0];
          last_s = 2'd3;
        end
      end
      ST_RESP: begin
        if (tx_ready) begin
          if (idx_r == last_r) begin
            state_s = ST_IDLE;
            txv_s   = 1'b0;
          end else begin
            idx_s = idx_r + 2'd1;
            txd_s = byte_sel(resp_r, idx_r + 2'd1);
          end
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        txv_s   = 1'b0;
      end
    endcase

    req_s = (state_s == ST_REQ) || (state_s == ST_ACCESS);
    we_s  = (state_s == ST_ACCESS) && is_wr_r;
    rxr_s = (state_s == ST_IDLE) || (state_s == ST_ADDR) || (state_s == ST_DATA);
`ifdef CHECKSUM_EN
    rxr_s = rxr_s || (state_s == ST_CHK);
`endif
  end

  // State and registered-output update with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      is_wr_r <= 1'b0;
      a_r     <= 5'd0;
      wd_r    <= 32'd0;
      we_r    <= 1'b0;
      req_r   <= 1'b0;
      txv_r   <= 1'b0;
      txd_r   <= 8'd0;
      rxr_r   <= 1'b0;
      cnt_r   <= 2'd0;
      idx_r   <= 2'd0;
      last_r  <= 2'd0;
      resp_r  <= 32'd0;
      tmo_r   <= {CW{1'b0}};
`ifdef CHECKSUM_EN
      chk_r   <= 8'd0;
`endif
    end else begin
      state_r <= state_s;
      is_wr_r <= is_wr_s;
      a_r     <= a_s;
      wd_r    <= wd_s;
      we_r    <= we_s;
      req_r   <= req_s;
      txv_r   <= txv_s;
      txd_r   <= txd_s;
      rxr_r   <= rxr_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      last_r  <= last_s;
      resp_r  <= resp_s;
      tmo_r   <= tmo_s;
`ifdef CHECKSUM_EN
      chk_r   <= chk_s;
`endif
    end
  end

  assign rx_ready = rxr_r;
  assign tx_data  = txd_r;
  assign tx_valid = txv_r;
  assign bus_req  = req_r;
  assign A        = a_r;
  assign WD       = wd_r;
  assign WE       = we_r;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge: table vectors, timeout/reset sequences and
// random commands checked against a command-level model of a 32-word peripheral space.
module tb_periph_bus_bridge;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic [4:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;

  periph_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .A(A), .WD(WD), .WE(WE), .RD(RD)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [32];
  logic [31:0] exp_regs [32];
  logic        preload;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h0001_A5C3 : (32'hC0DE_0000 | 32'(i * 257));
  endfunction

  assign RD = mem[A];

  // Peripheral register file seen by the bridge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (WE) begin
      mem[A] <= WD;
    end
  end

  int          cyc_req, cyc_we, gnt_dly;
  bit          gnt_tie, a_bad;
  logic [4:0]  a_hold, we_a;
  logic [31:0] we_wd;

  // Bus monitor and arbiter model: grant after gnt_dly request cycles, held while requested.
  always @(posedge clk) begin
    #1;
    if (bus_req) begin
      if (cyc_req == 0) a_hold = A;
      else if (A !== a_hold) a_bad = 1'b1;
      cyc_req++;
    end
    if (WE) begin
      cyc_we++;
      we_a  = A;
      we_wd = WD;
    end
    bus_gnt = gnt_tie || (bus_req && (cyc_req > gnt_dly));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xor_bytes(input logic [63:0] c, input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) x = x ^ c[8*i +: 8];
    return x;
  endfunction

  task automatic clear_mon(input int dly, input bit tie);
    cyc_req = 0; cyc_we = 0; a_bad = 1'b0; gnt_dly = dly; gnt_tie = tie;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && k < 100) begin @(negedge clk); k++; end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_accept: rx_ready got 0 expected 1");
    end else begin
      @(posedge clk);
    end
    #1 rx_valid = 1'b0;
  endtask

  task automatic recv_check(input string nm, input logic [31:0] rsp, input int rn,
                            input bit acc, input bit wr, input logic [4:0] ea,
                            input logic [31:0] ewd, input int dly, input int stall);
    int lat, k;
    logic [7:0] held;
    bit sbad;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!tx_valid && lat < 300);
    chk({nm, "_latency"}, 64'(lat), 64'(acc ? dly + 3 : 1));
    if (tx_valid) begin
      for (int j = 0; j < rn; j++) begin
        if (j > 0) begin
          k = 0;
          do begin @(negedge clk); k++; end while (!tx_valid && k < 20);
        end
        held = tx_data; sbad = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          if (!tx_valid || tx_data !== held) sbad = 1'b1;
        end
        if (stall > 0) chk($sformatf("%s_stall%0d", nm, j), 64'(sbad), 64'd0);
        tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        chk($sformatf("%s_byte%0d", nm, j), 64'(held), 64'(rsp[8*j +: 8]));
      end
      @(negedge clk);
      chk({nm, "_tx_idle"}, 64'(tx_valid), 64'd0);
    end
    chk({nm, "_req_cycles"}, 64'(cyc_req), 64'(acc ? dly + 2 : 0));
    chk({nm, "_we_cycles"}, 64'(cyc_we), 64'(wr ? 1 : 0));
    chk({nm, "_a_stable"}, 64'(a_bad), 64'd0);
    if (wr) begin
      chk({nm, "_we_addr"}, 64'(we_a), 64'(ea));
      chk({nm, "_we_data"}, 64'(we_wd), 64'(ewd));
    end
  endtask

  // Command-level model: response and side effect purely from the command bytes.
  function automatic void model_cmd(input logic [63:0] c, output logic [31:0] rsp,
                                    output int rn, output bit acc, output bit wr);
    acc = 1'b0; wr = 1'b0; rn = 1;
    if (c[7:0] != 8'h57 && c[7:0] != 8'h52) rsp = 32'h3F;
    else if (c[15:13] != 3'b000) rsp = 32'h45;
    else if (c[7:0] == 8'h57) begin rsp = 32'h4B; acc = 1'b1; wr = 1'b1; end
    else begin rsp = exp_regs[c[12:8]]; rn = 4; acc = 1'b1; end
  endfunction

  task automatic run_cmd(input string nm, input logic [63:0] c, input int n,
                         input logic [31:0] rsp, input int rn, input bit acc, input bit wr,
                         input int dly, input bit tie, input int stall);
    logic [63:0] cc;
    int nn;
    cc = c; nn = n;
`ifdef CHECKSUM_EN
    if (acc) begin cc[8*nn +: 8] = xor_bytes(c, n); nn++; end
`endif
    clear_mon(dly, tie);
    for (int i = 0; i < nn; i++) send_byte(cc[8*i +: 8]);
    recv_check(nm, rsp, rn, acc, wr, c[12:8], c[47:16], dly, stall);
    if (wr) exp_regs[c[12:8]] = c[47:16];
  endtask

  typedef struct packed {
    logic [63:0] cmd;
    logic [3:0]  n;
    logic [31:0] rsp;
    logic [2:0]  rn;
    logic        acc;
    logic        wr;
    logic [7:0]  dly;
    logic        tie;
    logic [3:0]  stall;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [63:0] c;
    logic [31:0] rsp;
    int rn, n, k, r;
    bit acc, wr;
    int bad;

    vecs[0] = '{cmd:64'h0000_DEAD_BEEF_1857, n:4'd6, rsp:32'h4B, rn:3'd1, acc:1'b1, wr:1'b1, dly:8'd0, tie:1'b1, stall:4'd0};
    vecs[1] = '{cmd:64'h0000_0000_0000_0052, n:4'd2, rsp:32'h0001_A5C3, rn:3'd4, acc:1'b1, wr:1'b0, dly:8'd0, tie:1'b0, stall:4'd0};
    vecs[2] = '{cmd:64'h0000_0000_0000_0052, n:4'd2, rsp:32'h0001_A5C3, rn:3'd4, acc:1'b1, wr:1'b0, dly:8'd20, tie:1'b0, stall:4'd5};
    vecs[3] = '{cmd:64'h0000_0000_0000_0033, n:4'd1, rsp:32'h3F, rn:3'd1, acc:1'b0, wr:1'b0, dly:8'd0, tie:1'b0, stall:4'd0};
    vecs[4] = '{cmd:64'h0000_0000_0000_2052, n:4'd2, rsp:32'h45, rn:3'd1, acc:1'b0, wr:1'b0, dly:8'd0, tie:1'b0, stall:4'd0};
    vecs[5] = '{cmd:64'h0000_0000_0000_1852, n:4'd2, rsp:32'hDEAD_BEEF, rn:3'd4, acc:1'b1, wr:1'b0, dly:8'd3, tie:1'b0, stall:4'd2};
    vecs[6] = '{cmd:64'h0000_1234_5678_1F57, n:4'd6, rsp:32'h4B, rn:3'd1, acc:1'b1, wr:1'b1, dly:8'd1, tie:1'b0, stall:4'd3};
    vecs[7] = '{cmd:64'h0000_0000_0000_1F52, n:4'd2, rsp:32'h1234_5678, rn:3'd4, acc:1'b1, wr:1'b0, dly:8'd0, tie:1'b0, stall:4'd0};
    vecs[8] = '{cmd:64'h0000_0000_0000_E057, n:4'd2, rsp:32'h45, rn:3'd1, acc:1'b0, wr:1'b0, dly:8'd0, tie:1'b0, stall:4'd0};

    rst_n = 1'b0; preload = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    bus_gnt = 1'b0; clear_mon(0, 1'b0);
    for (int i = 0; i < 32; i++) exp_regs[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst_A", 64'(A), 64'd0);
    chk("rst_WD", 64'(WD), 64'd0);
    chk("rst_WE", 64'(WE), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_rx_ready", 64'(rx_ready), 64'd1);

    for (int v = 0; v < 9; v++)
      run_cmd($sformatf("vec%0d", v), vecs[v].cmd, int'(vecs[v].n), vecs[v].rsp,
              int'(vecs[v].rn), vecs[v].acc, vecs[v].wr, int'(vecs[v].dly),
              vecs[v].tie, int'(vecs[v].stall));

    // Partial write abandoned after exactly TMO idle cycles; register 4 keeps its value.
    clear_mon(0, 1'b0);
    send_byte(8'h57); send_byte(8'h04); send_byte(8'h11);
    repeat (TMO) @(negedge clk);
    chk("tmo_no_write", 64'(cyc_we), 64'd0);
    run_cmd("tmo_read", 64'h0452, 2, init_word(4), 4, 1'b1, 1'b0, 0, 1'b0, 0);

    // One cycle short of the timeout the command survives and the byte wins.
    clear_mon(0, 1'b0);
    c = 64'h0000_DDCC_BBAA_0557;
    send_byte(8'h57); send_byte(8'h05); send_byte(8'hAA);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
`ifdef CHECKSUM_EN
    send_byte(xor_bytes(c, 6));
`endif
    recv_check("tmo_edge", 32'h4B, 1, 1'b1, 1'b1, 5'h05, 32'hDDCC_BBAA, 0, 0);
    exp_regs[5] = 32'hDDCC_BBAA;

`ifdef CHECKSUM_EN
    clear_mon(0, 1'b0);
    send_byte(8'h52); send_byte(8'h08); send_byte(8'h5A);
    recv_check("chk_good", exp_regs[8], 4, 1'b1, 1'b0, 5'h08, 32'h0, 0, 0);
    clear_mon(0, 1'b0);
    send_byte(8'h52); send_byte(8'h08); send_byte(8'h00);
    recv_check("chk_bad", 32'h45, 1, 1'b0, 1'b0, 5'h08, 32'h0, 0, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      c = {$urandom, $urandom};
      c[63:48] = 16'h0000;
      if (r < 5) c[7:0] = 8'h57;
      else if (r < 9) c[7:0] = 8'h52;
      else c[7:0] = 8'($urandom_range(0, 8'h50));
      if ($urandom_range(0, 9) != 0) c[15:13] = 3'b000;
      else c[15:13] = 3'($urandom_range(1, 7));
      model_cmd(c, rsp, rn, acc, wr);
      n = (c[7:0] != 8'h57 && c[7:0] != 8'h52) ? 1 : (!acc ? 2 : (wr ? 6 : 2));
      run_cmd($sformatf("rnd%0d", t), c, n, rsp, rn, acc, wr,
              $urandom_range(0, 6), 1'b0, $urandom_range(0, 3));
    end

    // Reset in the middle of a stalled response.
    clear_mon(0, 1'b0);
    c = 64'h0352;
    send_byte(8'h52); send_byte(8'h03);
`ifdef CHECKSUM_EN
    send_byte(xor_bytes(c, 2));
`endif
    k = 0;
    while (!tx_valid && k < 50) begin @(negedge clk); k++; end
    chk("mid_resp_tx_valid_before", 64'(tx_valid), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_resp_tx_valid", 64'(tx_valid), 64'd0);
    chk("mid_resp_rx_ready", 64'(rx_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("after_rst_tx_valid", 64'(tx_valid), 64'd0);

    // Reset while the grant is still pending.
    clear_mon(50, 1'b0);
    send_byte(8'h52); send_byte(8'h03);
`ifdef CHECKSUM_EN
    send_byte(xor_bytes(c, 2));
`endif
    k = 0;
    while (!bus_req && k < 20) begin @(negedge clk); k++; end
    chk("mid_req_bus_req_before", 64'(bus_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req_bus_req", 64'(bus_req), 64'd0);
    chk("mid_req_WE", 64'(WE), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd("post_rst_read", 64'h0552, 2, exp_regs[5], 4, 1'b1, 1'b0, 0, 1'b0, 1);

    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== exp_regs[i]) bad++;
    chk("mem_final_mismatches", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
